// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the pipelined RISC-V core's
//               hazard logic: hazard FSM state encoding, the x0 register
//               address and the default performance-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Default width of the stall/flush performance counters
  localparam int unsigned CNT_W_DEFAULT = 32;

  // Architectural zero register; a load targeting it never creates a hazard
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Hazard controller state: free-running, or frozen on a slow data access
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detection_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit_if
// Description : Bundle between the pipeline datapath and the hazard detection
//               unit.
//   master : pipeline side - drives ID/EX operand info, branch outcome and the
//            data-memory handshake; receives stall/flush controls + counters.
//   slave  : hazard unit side - the opposite directions.
//   Signals: ID_RS1addr_i, ID_RS2addr_i, ID_EX_MemRead_i, ID_EX_RDaddr_i,
//            Branch_taken_i, mem_req_i, mem_ack_i, PCWrite_o, IF_ID_Write_o,
//            IF_ID_Flush_o, ID_EX_NoOp_o, Pipe_Stall_o, stall_cnt_o,
//            flush_cnt_o
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_detection_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

  logic [4:0]       ID_RS1addr_i;
  logic [4:0]       ID_RS2addr_i;
  logic             ID_EX_MemRead_i;
  logic [4:0]       ID_EX_RDaddr_i;
  logic             Branch_taken_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             PCWrite_o;
  logic             IF_ID_Write_o;
  logic             IF_ID_Flush_o;
  logic             ID_EX_NoOp_o;
  logic             Pipe_Stall_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output ID_RS1addr_i, ID_RS2addr_i, ID_EX_MemRead_i, ID_EX_RDaddr_i,
           Branch_taken_i, mem_req_i, mem_ack_i,
    input  PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_NoOp_o,
           Pipe_Stall_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  ID_RS1addr_i, ID_RS2addr_i, ID_EX_MemRead_i, ID_EX_RDaddr_i,
           Branch_taken_i, mem_req_i, mem_ack_i,
    output PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_NoOp_o,
           Pipe_Stall_o, stall_cnt_o, flush_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/hazard_perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : hazard_perf_counter
// Description : CNT_W-bit event counter that wraps modulo 2^CNT_W.
//   clk_i   in  1      clock
//   rst_i   in  1      asynchronous reset, active-low (clears the count)
//   i_en    in  1      count one event on this edge
//   o_count out CNT_W  current count
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  // Natural overflow of the adder gives the wrap-around
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + c_one;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit
// Description : ID-stage stall/flush controller. Resolves hazards that EX
//               forwarding cannot: load-use (one bubble), taken branch in ID
//               (one IF/ID flush) and multi-cycle data-memory access (full
//               pipeline freeze). Keeps stall and flush event counters.
//   clk_i  in  1   pipeline clock
//   rst_i  in  1   asynchronous reset, active-low
//   bus    slave modport of hazard_detection_unit_if (operand info, branch,
//          memory handshake in; PC/IF-ID/ID-EX controls and counters out)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detection_unit
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hazard_detection_unit_if.slave bus
);

  hazard_state_t    r_state;
  hazard_state_t    w_state_next;

  logic             w_load_use;
  logic             w_mem_hold;
  logic             w_pc_write;
  logic             w_if_id_write;
  logic             w_if_id_flush;
  logic             w_id_ex_noop;
  logic             w_pipe_stall;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  // A load in EX whose destination feeds the instruction in ID; x0 is exempt
  // because it reads as zero regardless of the load result.
  assign w_load_use = bus.ID_EX_MemRead_i
                   && (bus.ID_EX_RDaddr_i != REG_ZERO)
                   && ((bus.ID_EX_RDaddr_i == bus.ID_RS1addr_i)
                    || (bus.ID_EX_RDaddr_i == bus.ID_RS2addr_i));

  // An ack in the request cycle costs nothing; otherwise freeze until ack.
  assign w_mem_hold = ((r_state == RUN) && bus.mem_req_i && !bus.mem_ack_i)
                   || ((r_state == MEM_WAIT) && !bus.mem_ack_i);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Only an ack leaves MEM_WAIT; a request dropped without
  // an ack is a protocol violation and deliberately keeps the pipe frozen.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:      if (bus.mem_req_i && !bus.mem_ack_i) w_state_next = MEM_WAIT;
      MEM_WAIT: if (bus.mem_ack_i)                   w_state_next = RUN;
      default:                                       w_state_next = RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Memory freeze outranks load-use because ID is frozen and
  // gets re-evaluated on release; load-use outranks a taken branch because
  // the branch compared stale operands.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_write    = 1'b0;
    w_if_id_write = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_noop  = 1'b0;
    w_pipe_stall  = 1'b0;
    if (!rst_i) begin
      // hold every control inactive while in reset
    end else if (w_mem_hold) begin
      w_pipe_stall  = 1'b1;
    end else if (w_load_use) begin
      w_id_ex_noop  = 1'b1;
    end else if (bus.Branch_taken_i) begin
      w_if_id_flush = 1'b1;
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
    end else begin
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  hazard_perf_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_en    (w_pipe_stall || w_id_ex_noop),
    .o_count (w_stall_cnt)
  );

  hazard_perf_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_en    (w_if_id_flush),
    .o_count (w_flush_cnt)
  );

  assign bus.PCWrite_o     = w_pc_write;
  assign bus.IF_ID_Write_o = w_if_id_write;
  assign bus.IF_ID_Flush_o = w_if_id_flush;
  assign bus.ID_EX_NoOp_o  = w_id_ex_noop;
  assign bus.Pipe_Stall_o  = w_pipe_stall;
  assign bus.stall_cnt_o   = w_stall_cnt;
  assign bus.flush_cnt_o   = w_flush_cnt;

endmodule
`default_nettype wire

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Stall and flush controller for the 5-stage pipelined RISC-V CPU; the producer-side counterpart to the EX-stage forwarding logic. It detects hazards that forwarding cannot resolve:
- load-use dependences, which cost one bubble;
- taken branches resolved in ID, which cost one IF/ID flush;
- multi-cycle data-memory accesses, which freeze the whole pipeline.

It sits in ID, drives the PC, IF/ID and ID/EX write/flush controls, and keeps stall/flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk_i  in  1  pipeline clock
- rst_i  in  1  asynchronous reset, active-low
- ID_RS1addr_i  in  5  rs1 of instruction in ID
- ID_RS2addr_i  in  5  rs2 of instruction in ID
- ID_EX_MemRead_i  in  1  instruction in EX is a load
- ID_EX_RDaddr_i  in  5  rd of instruction in EX
- Branch_taken_i  in  1  branch in ID resolved taken
- mem_req_i  in  1  MEM stage holds a load/store (level, held until ack)
- mem_ack_i  in  1  data memory completes access this cycle (1-cycle pulse)
- PCWrite_o  out  1  PC may update
- IF_ID_Write_o  out  1  IF/ID register may update
- IF_ID_Flush_o  out  1  zero IF/ID on next edge
- ID_EX_NoOp_o  out  1  load bubble (all control zero) into ID/EX
- Pipe_Stall_o  out  1  freeze every pipeline register and the PC
- stall_cnt_o  out  CNT_W  cycles with Pipe_Stall_o or load-use bubble
- flush_cnt_o  out  CNT_W  number of IF/ID flushes issued

## Operation
- Signal definitions:
  - load_use = ID_EX_MemRead_i && ID_EX_RDaddr_i != 0 && (ID_EX_RDaddr_i == ID_RS1addr_i || ID_EX_RDaddr_i == ID_RS2addr_i).
  - mem_hold = (state==RUN && mem_req_i && !mem_ack_i) || (state==MEM_WAIT && !mem_ack_i).
- FSM states:
  - RUN: MEM_WAIT entered when mem_req_i && !mem_ack_i.
  - MEM_WAIT: return to RUN on mem_ack_i. mem_req_i dropping without ack is a protocol violation; the FSM stays in MEM_WAIT.
- Priority (highest first):
  1. mem_hold: Pipe_Stall_o=1, PCWrite_o=0, IF_ID_Write_o=0, ID_EX_NoOp_o=0, IF_ID_Flush_o=0. The branch/load-use decision is deferred because ID is frozen and re-evaluated once released.
  2. load_use: PCWrite_o=0, IF_ID_Write_o=0, ID_EX_NoOp_o=1, IF_ID_Flush_o=0. A simultaneous Branch_taken_i is ignored because its operands are not yet valid.
  3. Branch_taken_i: IF_ID_Flush_o=1, PCWrite_o=1, IF_ID_Write_o=1.
  4. Otherwise: PCWrite_o=1, IF_ID_Write_o=1, all others 0.
- Counters:
  - stall_cnt increments on each cycle with Pipe_Stall_o=1 or ID_EX_NoOp_o=1.
  - flush_cnt increments on each cycle with IF_ID_Flush_o=1.
  - Both wrap modulo 2^CNT_W.
- Outputs are combinational from state and inputs. State and counters are registered.

## Timing
- Reset (rst_i=0): state=RUN, both counters 0. While in reset, PCWrite_o=0, IF_ID_Write_o=0, IF_ID_Flush_o=0, ID_EX_NoOp_o=0, Pipe_Stall_o=0, independent of inputs.
- Load-use costs exactly 1 cycle: in the following cycle the load is in MEM and forwarding supplies the value.
- Branch flush costs exactly 1 cycle.
- Memory access with ack in the request cycle causes zero stall cycles. An ack N cycles after the request causes N stall cycles.
- Counters reflect a qualifying cycle on the next clock edge (1-cycle latency).
- Reset asserted in MEM_WAIT returns the FSM to RUN immediately and clears the counters. An ack arriving after reset release is ignored unless mem_req_i is high.
- Load-use to register x0 never stalls.

## Structure
- Shared package cpu_pkg holds:
  - hazard state enum (RUN, MEM_WAIT);
  - REG_ZERO constant (5'd0);
  - default CNT_W.
- One sub-module: hazard_perf_counter (CNT_W-wide wrapping counter with async active-low reset and increment enable), instantiated twice.

## Test plan
- Load-use: ID_EX_MemRead_i=1, ID_EX_RDaddr_i=5, ID_RS2addr_i=5 for 1 cycle -> PCWrite_o=0, IF_ID_Write_o=0, ID_EX_NoOp_o=1 that cycle; stall_cnt_o=1 next cycle.
- Load to x0: ID_EX_RDaddr_i=0, ID_RS1addr_i=0 -> no stall; PCWrite_o=1.
- Taken branch plus load-use in the same cycle -> ID_EX_NoOp_o=1, IF_ID_Flush_o=0, flush_cnt_o unchanged. Next cycle with load_use=0 and Branch_taken_i=1 -> IF_ID_Flush_o=1, flush_cnt_o=1.
- Memory wait: mem_req_i=1 with mem_ack_i 3 cycles later -> Pipe_Stall_o=1 for exactly 3 cycles; stall_cnt_o=3; state back to RUN. Same-cycle ack -> Pipe_Stall_o never asserts.
- Memory stall with simultaneous load-use and branch -> only Pipe_Stall_o asserted; ID_EX_NoOp_o=0 and IF_ID_Flush_o=0 until ack.
- Reset pulse mid MEM_WAIT -> outputs take reset values, counters 0, state RUN. With mem_req_i=0 after release -> PCWrite_o=1.
